// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums a frame of COUNT unsigned 16-bit products into an
//               ACC_W-bit accumulator. When the frame is complete the block
//               holds the result and waits for an acknowledge. A sticky flag
//               records any carry out of the accumulator during the frame.
// Ports       : i_Clk      - clock, rising edge active
//               i_Rst_n    - asynchronous active-low reset
//               i_Clear    - synchronous frame abort, highest priority
//               i_P        - unsigned product input (16 bits)
//               i_Valid    - i_P valid this cycle
//               o_Ready    - block accepts i_P this cycle (ACCUM state)
//               o_Acc      - registered running / final sum
//               o_Count    - products accepted in the current frame
//               o_Valid    - frame complete, o_Acc is final (HOLD state)
//               i_Ack      - downstream consumed the final sum
//               o_Overflow - sticky carry-out flag for the current frame
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
    parameter int ACC_W = 24,   // accumulator width, 16..32
    parameter int COUNT = 8     // products per frame, 1..255
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Clear,
    input  logic [15:0]      i_P,
    input  logic             i_Valid,
    output logic             o_Ready,
    output logic [ACC_W-1:0] o_Acc,
    output logic [7:0]       o_Count,
    output logic             o_Valid,
    input  logic             i_Ack,
    output logic             o_Overflow
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] COUNT_LAST = 8'(COUNT);

    state_t           state;
    logic [ACC_W:0]   sum_ext;     // one extra bit captures the carry-out
    logic [7:0]       count_next;
    logic             transfer;

    assign sum_ext    = {1'b0, o_Acc} + {{(ACC_W - 15){1'b0}}, i_P};
    assign count_next = o_Count + 8'd1;
    // o_Ready is a register, so this term has no input-to-output path.
    assign transfer   = i_Valid & o_Ready;

    // o_Ready / o_Valid are registered alongside the state so that both
    // always reflect the state register exactly.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= ST_ACCUM;
            o_Ready    <= 1'b1;
            o_Valid    <= 1'b0;
            o_Acc      <= '0;
            o_Count    <= '0;
            o_Overflow <= 1'b0;
        end else if (i_Clear) begin
            // Abort wins over everything, including a concurrent transfer.
            state      <= ST_ACCUM;
            o_Ready    <= 1'b1;
            o_Valid    <= 1'b0;
            o_Acc      <= '0;
            o_Count    <= '0;
            o_Overflow <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (transfer) begin
                        o_Acc   <= sum_ext[ACC_W-1:0];
                        o_Count <= count_next;
                        if (sum_ext[ACC_W]) begin
                            o_Overflow <= 1'b1;
                        end
                        if (count_next == COUNT_LAST) begin
                            state   <= ST_HOLD;
                            o_Ready <= 1'b0;
                            o_Valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result stays frozen until acknowledged; no product is
                    // taken in the acknowledge cycle since o_Ready is low.
                    if (i_Ack) begin
                        state      <= ST_ACCUM;
                        o_Ready    <= 1'b1;
                        o_Valid    <= 1'b0;
                        o_Acc      <= '0;
                        o_Count    <= '0;
                        o_Overflow <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_ACCUM;
                    o_Ready <= 1'b1;
                    o_Valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_accumulator
// Description : Self-checking bench for product_accumulator. Two instances
//               (24-bit/8 products and 16-bit/2 products) share the same
//               stimulus; an arithmetic reference model predicts each one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b0;
    logic        vin   = 1'b0;
    logic        ack   = 1'b0;
    logic [15:0] p     = 16'h0;

    logic        rdy0, vld0, ovf0;
    logic [23:0] acc0;
    logic [7:0]  cnt0;
    logic        rdy1, vld1, ovf1;
    logic [15:0] acc1;
    logic [7:0]  cnt1;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(24), .COUNT(8)) u0 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clr), .i_P(p), .i_Valid(vin),
        .o_Ready(rdy0), .o_Acc(acc0), .o_Count(cnt0), .o_Valid(vld0),
        .i_Ack(ack), .o_Overflow(ovf0)
    );

    product_accumulator #(.ACC_W(16), .COUNT(2)) u1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clr), .i_P(p), .i_Valid(vin),
        .o_Ready(rdy1), .o_Acc(acc1), .o_Count(cnt1), .o_Valid(vld1),
        .i_Ack(ack), .o_Overflow(ovf1)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: frame sum as plain integer arithmetic
    longint m_sum [2];
    int     m_cnt [2];
    bit     m_ovf [2];
    bit     m_hold[2];
    bit     prev_vld[2];
    int     W[2] = '{24, 16};
    int     N[2] = '{8, 2};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_sum[i]  = 0;
        m_cnt[i]  = 0;
        m_ovf[i]  = 0;
        m_hold[i] = 0;
    endtask

    task automatic model_edge(input int i);
        longint s;
        longint lim;
        exp_t   e;
        lim = longint'(1) << W[i];
        if (clr) begin
            model_reset(i);
        end else if (m_hold[i]) begin
            if (ack) model_reset(i);
        end else if (vin) begin
            s = m_sum[i] + longint'(p);
            if (s >= lim) begin
                m_ovf[i] = 1;
                s = s - lim;
            end
            m_sum[i] = s;
            m_cnt[i] = m_cnt[i] + 1;
            if (m_cnt[i] == N[i]) begin
                m_hold[i] = 1;
                e.acc = 32'(m_sum[i]);
                e.cnt = 8'(m_cnt[i]);
                e.ovf = m_ovf[i];
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    task automatic mon_inst(input int i, input logic rdy, input logic vld, input logic ovf,
                            input logic [31:0] acc, input logic [7:0] cnt);
        exp_t  e;
        string tag;
        tag = (i == 0) ? "u0" : "u1";
        chk({tag, " ready"},    64'(rdy), 64'(!m_hold[i]));
        chk({tag, " valid"},    64'(vld), 64'(m_hold[i]));
        chk({tag, " acc"},      64'(acc), 64'(m_sum[i]));
        chk({tag, " count"},    64'(cnt), 64'(m_cnt[i]));
        chk({tag, " overflow"}, 64'(ovf), 64'(m_ovf[i]));
        if (vld === 1'b1 && !prev_vld[i]) begin
            if ((i == 0 && q0.size() > 0) || (i == 1 && q1.size() > 0)) begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk({tag, " frame acc"}, 64'(acc), 64'(e.acc));
                chk({tag, " frame cnt"}, 64'(cnt), 64'(e.cnt));
                chk({tag, " frame ovf"}, 64'(ovf), 64'(e.ovf));
            end else begin
                chk({tag, " frame unexpected"}, 64'(1), 64'(0));
            end
        end
        prev_vld[i] = (vld === 1'b1);
    endtask

    // Apply one cycle of inputs; returns at the following falling edge.
    task automatic drive(input logic v, input logic [15:0] pp, input logic a, input logic c);
        vin = v;
        p   = pp;
        ack = a;
        clr = c;
        @(negedge clk);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        prev_vld[0] = 0;
        prev_vld[1] = 0;

        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    model_reset(0);
                    model_reset(1);
                end else begin
                    model_edge(0);
                    model_edge(1);
                end
            end
            forever begin
                @(negedge clk);
                mon_inst(0, rdy0, vld0, ovf0, 32'(acc0), cnt0);
                mon_inst(1, rdy1, vld1, ovf1, 32'(acc1), cnt1);
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset ready", 64'(rdy0), 64'(1));
        chk("reset valid", 64'(vld0), 64'(0));
        chk("reset acc",   64'(acc0), 64'(0));
        chk("reset count", 64'(cnt0), 64'(0));
        chk("reset ovf",   64'(ovf0), 64'(0));
        rst_n = 1'b1;

        // Basic frame: 8 x 0x64
        for (int k = 0; k < 8; k++) drive(1'b1, 16'h0064, 1'b0, 1'b0);
        chk("basic acc",   64'(acc0), 64'h320);
        chk("basic count", 64'(cnt0), 64'd8);
        chk("basic valid", 64'(vld0), 64'(1));
        chk("basic ovf",   64'(ovf0), 64'(0));
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("basic ack acc",   64'(acc0), 64'(0));
        chk("basic ack ready", 64'(rdy0), 64'(1));

        // Overflow on the 16-bit, 2-product instance
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
        drive(1'b1, 16'h0002, 1'b0, 1'b0);
        chk("ovf acc",   64'(acc1), 64'h0001);
        chk("ovf flag",  64'(ovf1), 64'(1));
        chk("ovf valid", 64'(vld1), 64'(1));
        chk("wide acc",  64'(acc0), 64'h10001);

        // Backpressure: complete u0's frame, then stall in HOLD
        for (int k = 0; k < 6; k++) drive(1'b1, 16'h0010, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'h1234, 1'b0, 1'b0);
            chk("bp ready", 64'(rdy0), 64'(0));
            chk("bp acc",   64'(acc0), 64'h10061);
        end
        drive(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("bp ack acc",   64'(acc0), 64'(0));
        chk("bp ack count", 64'(cnt0), 64'(0));

        // Gapped input
        drive(1'b1, 16'h00FF, 1'b0, 1'b0);
        drive(1'b0, 16'hFFFF, 1'b0, 1'b0);
        drive(1'b1, 16'h00FF, 1'b0, 1'b0);
        drive(1'b0, 16'hFFFF, 1'b0, 1'b0);
        chk("gap acc",   64'(acc0), 64'h1FE);
        chk("gap count", 64'(cnt0), 64'd2);

        // Clear colliding with the 4th transfer
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, 16'h0005, 1'b0, 1'b0);
        drive(1'b1, 16'h0005, 1'b0, 1'b1);
        chk("clr acc",   64'(acc0), 64'(0));
        chk("clr count", 64'(cnt0), 64'(0));
        chk("clr ready", 64'(rdy0), 64'(1));

        // Asynchronous reset while in HOLD
        for (int k = 0; k < 8; k++) drive(1'b1, 16'h0101, 1'b0, 1'b0);
        chk("pre-rst valid", 64'(vld0), 64'(1));
        p = 16'h0007;
        #1 rst_n = 1'b0;
        #1;
        chk("arst valid", 64'(vld0), 64'(0));
        chk("arst acc",   64'(acc0), 64'(0));
        chk("arst ready", 64'(rdy0), 64'(1));
        chk("arst count", 64'(cnt0), 64'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst acc",   64'(acc0), 64'h7);
        chk("post-rst count", 64'(cnt0), 64'd1);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            drive(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) == 0,
                  ($urandom % 50) == 0);
        end
        for (int k = 0; k < 3; k++) drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("u0 queue drained", 64'(q0.size()), 64'(0));
        chk("u1 queue drained", 64'(q1.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 24, giving the accumulator width in bits (legal range 16..32).
REQ-002 SHALL have parameter COUNT, default 8, giving the number of products per accumulation frame (legal range 1..255).
REQ-003 SHALL have port i_Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_Clear, input, 1 bit: synchronous frame abort/clear.
REQ-006 SHALL have port i_P, input, 16 bits: unsigned product from the upstream 8x8 multiplier.
REQ-007 SHALL have port i_Valid, input, 1 bit: i_P is valid this cycle.
REQ-008 SHALL have port o_Ready, output, 1 bit: the block accepts i_P this cycle.
REQ-009 SHALL have port o_Acc, output, ACC_W bits: the registered running or final sum.
REQ-010 SHALL have port o_Count, output, 8 bits: the number of products accepted in the current frame.
REQ-011 SHALL have port o_Valid, output, 1 bit: the frame is complete and o_Acc is final.
REQ-012 SHALL have port i_Ack, input, 1 bit: downstream consumption of the final o_Acc.
REQ-013 SHALL have port o_Overflow, output, 1 bit: sticky flag, set if any addition in the current frame carried out of ACC_W bits.

Function
REQ-014 SHALL implement a two-state FSM: ACCUM (o_Ready=1, o_Valid=0) and HOLD (o_Ready=0, o_Valid=1).
REQ-015 SHALL define a transfer as i_Valid=1 and o_Ready=1 at a rising edge; i_P is ignored in every other cycle.
REQ-016 SHALL, on a transfer, register o_Acc <= (o_Acc + zero-extended i_P) mod 2^ACC_W and o_Count <= o_Count+1; the result is visible one cycle after the transfer.
REQ-017 SHALL set o_Overflow on a transfer whose ACC_W-bit addition produces a carry-out; o_Overflow SHALL remain set until the frame is cleared.
REQ-018 SHALL move from ACCUM to HOLD on the transfer that makes o_Count equal COUNT, so o_Valid asserts on the following cycle.
REQ-019 SHALL hold o_Acc, o_Count and o_Overflow stable in HOLD until i_Ack=1.
REQ-020 SHALL, in HOLD with i_Ack=1, return to ACCUM on the next edge with o_Acc=0, o_Count=0 and o_Overflow=0.
REQ-021 SHALL NOT accept a product in the cycle i_Ack is sampled, because o_Ready=0 in HOLD; the first new transfer is possible one cycle later.
REQ-022 SHALL ignore i_Ack while in ACCUM.
REQ-023 SHALL treat i_Clear=1 as highest synchronous priority in any state, any cycle: the next state is ACCUM with o_Acc=0, o_Count=0 and o_Overflow=0.
REQ-024 SHALL discard a concurrent transfer when i_Clear=1 coincides with it.
REQ-025 SHALL, with COUNT=1, enter HOLD after each single transfer.
REQ-026 SHALL drive o_Ready and o_Valid as decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, while i_Rst_n=0, asynchronously force state=ACCUM, o_Acc=0, o_Count=0, o_Overflow=0, o_Valid=0 and o_Ready=1.
REQ-028 SHALL, when reset is asserted mid-frame or in HOLD, discard the partial or final sum with no output pulse.
REQ-029 SHALL, on deassertion of i_Rst_n, accept transfers from the first rising edge after release.

Verification
REQ-030 Basic frame (defaults): 8 back-to-back transfers of i_P=0x0064 -> o_Acc=0x000320, o_Count=8, o_Valid=1 one cycle after the 8th transfer, o_Overflow=0.
REQ-031 Overflow (ACC_W=16, COUNT=2): transfers i_P=0xFFFF then 0x0002 -> o_Acc=0x0001, o_Overflow=1, o_Valid=1.
REQ-032 Backpressure: hold i_Ack=0 for 5 cycles in HOLD while i_Valid=1 with i_P=0x1234 -> o_Ready=0, o_Acc unchanged; after i_Ack=1, o_Acc=0 and o_Count=0 next cycle.
REQ-033 Gapped input: i_Valid toggled 1,0,1,0 with i_P=0x00FF on valid cycles and 0xFFFF on invalid cycles -> after 2 transfers o_Acc=0x0001FE, o_Count=2.
REQ-034 Clear collision: i_Clear=1 in the same cycle as the 4th transfer -> o_Acc=0, o_Count=0, state ACCUM next cycle, and that product is dropped.
REQ-035 Async reset: assert i_Rst_n=0 between clock edges in HOLD -> o_Valid=0, o_Acc=0 and o_Ready=1 immediately, without waiting for a clock edge.
